// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Debounces three bouncing, asynchronous pins (two switches and an enable)
// for the LED blinker. Each pin first passes through a 2-flop synchronizer and
// then through an independent qualification channel. A channel accepts a new
// level only after the synchronized value has differed from the current
// output for DEBOUNCE_CNT consecutive cycles. Any bounce back restarts
// qualification from the beginning.
//
// Latency: if edge t is the first edge to sample a new, stable raw value,
// the debounced output updates on edge t+DEBOUNCE_CNT+2.
//
// Parameters
//   DEBOUNCE_CNT  consecutive stable cycles needed to accept a level (2..65535)
//   CNT_W         width of each per-channel stability counter
//
// Ports
//   clock     in   system clock, all logic on its rising edge
//   reset     in   synchronous active-high reset, highest priority
//   sw1_raw   in   bouncing pin of switch 1
//   sw2_raw   in   bouncing pin of switch 2
//   en_raw    in   bouncing enable pin
//   switch_1  out  debounced switch 1 level (registered)
//   switch_2  out  debounced switch 2 level (registered)
//   enable    out  debounced enable level (registered)
//   changed   out  one-cycle pulse, high the cycle after any output updates
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int DEBOUNCE_CNT = 250,
  parameter int CNT_W        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sw1_raw,
  input  logic sw2_raw,
  input  logic en_raw,
  output logic switch_1,
  output logic switch_2,
  output logic enable,
  output logic changed
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // Terminal count: the qualifying sample is the one seen with the counter
  // already at DEBOUNCE_CNT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  // Channel order: bit 0 = switch 1, bit 1 = switch 2, bit 2 = enable.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] out_q;
  logic [2:0] upd;
  logic       changed_q;

  assign raw = {en_raw, sw2_raw, sw1_raw};

  // Synchronizer: raw pins are only ever used through sync2.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Three identical, independent qualification channels.
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_r;
    logic             out_nxt;
    logic             upd_c;

    always_ff @(posedge clock) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        out_r <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        out_r <= out_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out_r;
      upd_c     = 1'b0;
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (sync2[ch] != out_r) begin
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (sync2[ch] == out_r) begin
            // Bounced back to the current level: abandon this attempt.
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            // The >= keeps the counter from ever running past the terminal
            // count, so it cannot wrap.
            out_nxt   = sync2[ch];
            upd_c     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign out_q[ch] = out_r;
    assign upd[ch]   = upd_c;
  end

  // One pulse regardless of how many channels update on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd;
    end
  end

  assign switch_1 = out_q[0];
  assign switch_2 = out_q[1];
  assign enable   = out_q[2];
  assign changed  = changed_q;

endmodule
